// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and elaboration helpers for the sliced, pipelined adder.
// STAGES is derived from WIDTH/CHUNK; width_ok guards the divisibility rule.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder.
// master = producer/consumer side, slave = the adder.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  // Handshake: a beat moves only in a cycle where valid && ready are both high;
  // the sender holds valid and data stable until that cycle, and ready may
  // depend combinationally on downstream ready.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, A, B, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, A, B, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice; c_msb_in is the carry into the
// slice MSB so the top slice can form the signed overflow flag.
module chunk_adder
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract, one CHUNK-bit slice per stage with the carry
// registered between stages; valid/ready on both sides, last stage = output.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_adder_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!width_ok(WIDTH, CHUNK)) begin : g_width_check
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Row k is stage k: operand slices still to be consumed plus result slices 0..k.
  logic [CHUNK-1:0]  r_a   [STAGES][STAGES];
  logic [CHUNK-1:0]  r_b   [STAGES][STAGES];
  logic [CHUNK-1:0]  r_sum [STAGES][STAGES];
  logic              r_sub [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic              r_ovf;

  logic [STAGES-1:0] w_load;
  logic [CHUNK-1:0]  w_a_sl [STAGES];
  logic [CHUNK-1:0]  w_b_sl [STAGES];
  logic [CHUNK-1:0]  w_s    [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_co;
  logic [STAGES-1:0] w_cm;
  logic [WIDTH-1:0]  w_sum;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_sl[k] = bus.A[CHUNK-1:0];
      assign w_b_sl[k] = bus.B[CHUNK-1:0] ^ {CHUNK{bus.sub}};
      assign w_cin[k]  = bus.sub | bus.carry_in;
    end else begin : g_next
      assign w_a_sl[k] = r_a[k-1][k];
      assign w_b_sl[k] = r_b[k-1][k] ^ {CHUNK{r_sub[k-1]}};
      assign w_cin[k]  = r_carry[k-1];
    end

    chunk_adder #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a        (w_a_sl[k]),
      .b        (w_b_sl[k]),
      .cin      (w_cin[k]),
      .s        (w_s[k]),
      .cout     (w_co[k]),
      .c_msb_in (w_cm[k])
    );
  end

  // A stage may load when empty or when it drains forward in the same cycle.
  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = !r_valid[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_load[k] = !r_valid[k] || w_load[k+1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_sub[k] <= 1'b0;
        for (int j = 0; j < STAGES; j++) begin
          r_a[k][j]   <= '0;
          r_b[k][j]   <= '0;
          r_sum[k][j] <= '0;
        end
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= bus.in_valid;
        r_sub[0]   <= bus.sub;
        r_carry[0] <= w_co[0];
        for (int j = 0; j < STAGES; j++) begin
          r_a[0][j]   <= bus.A[j*CHUNK +: CHUNK];
          r_b[0][j]   <= bus.B[j*CHUNK +: CHUNK];
          r_sum[0][j] <= (j == 0) ? w_s[0] : '0;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_sub[k]   <= r_sub[k-1];
          r_carry[k] <= w_co[k];
          for (int j = 0; j < STAGES; j++) begin
            r_a[k][j]   <= r_a[k-1][j];
            r_b[k][j]   <= r_b[k-1][j];
            r_sum[k][j] <= (j == k) ? w_s[k] : r_sum[k-1][j];
          end
        end
      end
      if (w_load[STAGES-1]) begin
        r_ovf <= w_co[STAGES-1] ^ w_cm[STAGES-1];
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < STAGES; j++) begin
      w_sum[j*CHUNK +: CHUNK] = r_sum[STAGES-1][j];
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.sum       = w_sum;
  assign bus.carry_out = r_carry[STAGES-1];
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Stream bench for pipelined_adder: directed corner cases plus randomized
// traffic with backpressure, checked against an arithmetic reference model.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int W = 32;
  localparam int C = 8;
  localparam int S = W / C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  bit lat_on = 1'b0;
  bit rnd_done = 1'b0;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  logic [W+1:0] prev_out;
  bit           prev_stall = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; returns {overflow, carry_out, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    longint ua, ub, sa, sb, u, sr, lim;
    logic co, ov;
    ua  = a;
    ub  = b;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (sub) begin
      u  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      u  = ua + ub + longint'(cin);
      co = (u >= (longint'(1) << W));
      sr = sa + sb + longint'(cin);
    end
    ov = (sr >= lim) || (sr < -lim);
    return {ov, co, u[W-1:0]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    int a_cyc;
    cyc++;
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_eq("hold_stable", {bus.out_valid, bus.overflow, bus.carry_out, bus.sum},
                 {1'b1, prev_out});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", bus.out_valid, 0);
        end else begin
          e     = exp_q.pop_front();
          a_cyc = acc_q.pop_front();
          check_eq("sum", bus.sum, e[W-1:0]);
          check_eq("carry_out", bus.carry_out, e[W]);
          check_eq("overflow", bus.overflow, e[W+1]);
          if (lat_on) check_eq("latency", cyc - a_cyc, S);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_model(bus.A, bus.B, bus.carry_in, bus.sub));
        acc_q.push_back(cyc);
        acc_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.overflow, bus.carry_out, bus.sum};
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.carry_in = cin;
    bus.sub      = sub;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("in_ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] corners [6];
    corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_00FF, 32'h00FF_FF00};
    if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.carry_in = 1'b0;
    bus.sub      = 1'b0;
    bus.out_ready = 1'b1;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_sum", bus.sum, 0);
    check_eq("rst_carry_out", bus.carry_out, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 2: full-width carry ripple
    lat_on = 1'b1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();

    // 3: back-to-back beats, one result per cycle
    send(32'd250, 32'd250, 1'b0, 1'b0);
    send(32'd128, 32'd128, 1'b1, 1'b0);
    send(32'd220, 32'd250, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // 4: subtract and signed overflow
    send(32'd5, 32'd7, 1'b0, 1'b1);
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    drain();

    // 5: stall with a full pipeline
    lat_on        = 1'b0;
    acc_cnt       = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        check_eq("stall_accepted", acc_cnt, S);
        check_eq("stall_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("stall_total", acc_cnt, 10);

    // 6: asynchronous reset with beats in flight
    lat_on = 1'b1;
    send(32'd10, 32'd20, 1'b0, 1'b0);
    send(32'd30, 32'd40, 1'b0, 1'b0);
    send(32'd50, 32'd60, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("pre_reset_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", bus.out_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_eq("post_rst_quiet", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'd3, 32'd4, 1'b0, 1'b0);
    drain();

    // 7: randomized traffic with random backpressure
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
